// File: rtl/arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Port indices, lock FSM states and the read-return tag format.
package arb_pkg;
    localparam int PORT_CPU   = 0;
    localparam int PORT_EXT   = 1;
    localparam int MAX_RD_LAT = 4;

    typedef enum logic [1:0] {ARB_FREE, ARB_LOCK0, ARB_LOCK1} lock_state_e;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signals of the data memory arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          req_i;
    logic [1:0]          we_i;
    logic [2*ADDR_W-1:0] addr_i;
    logic [2*DATA_W-1:0] wdata_i;
    logic [1:0]          lock_i;
    logic [1:0]          gnt_o;
    logic                cpu_stall_o;
    logic [1:0]          rvalid_o;
    logic [DATA_W-1:0]   rdata_o;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_data_in;
    logic [DATA_W-1:0]   mem_data_out;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, lock_i, mem_data_out,
        output gnt_o, cpu_stall_o, rvalid_o, rdata_o,
               mem_read, mem_write, mem_address, mem_data_in
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, lock_i, mem_data_out,
        input  gnt_o, cpu_stall_o, rvalid_o, rdata_o,
               mem_read, mem_write, mem_address, mem_data_in
    );
endinterface

// File: rtl/arb_rd_tag_pipe.sv
// Read-return tag shift register: a tag pushed at grant emerges
// exactly MEM_RD_LAT cycles later, in alongside mem_data_out.
module arb_rd_tag_pipe
    import arb_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t push_i,
    output rd_tag_t tag_o
);
    rd_tag_t [MEM_RD_LAT-1:0] tag_q, tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = push_i;
        for (int i = 1; i < MEM_RD_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else       tag_q <= tag_d;
    end

    assign tag_o = tag_q[MEM_RD_LAT-1];
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: CPU priority, starvation override for port 1,
// in-order read return. Optional ownership lock FSM under ARB_LOCK_EN.
module data_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_RD_LAT = 1,
    parameter int MAX_WAIT   = 8
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] gnt;
    logic [1:0] lock_only;   // non-zero: only this port may be granted
    logic       win;
    logic [1:0] rv;
    rd_tag_t    push, tag;

`ifdef ARB_LOCK_EN
    lock_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ARB_FREE;
        else       state_q <= state_d;
    end

    // A lock holds only while its owner keeps lock_i high; the release cycle arbitrates normally.
    always_comb begin
        lock_only = 2'b00;
        case (state_q)
            ARB_LOCK0: if (bus.lock_i[PORT_CPU]) lock_only = 2'b01;
            ARB_LOCK1: if (bus.lock_i[PORT_EXT]) lock_only = 2'b10;
            default:   lock_only = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (lock_only == 2'b00) begin
            state_d = ARB_FREE;
            if (gnt[PORT_CPU] && bus.lock_i[PORT_CPU])      state_d = ARB_LOCK0;
            else if (gnt[PORT_EXT] && bus.lock_i[PORT_EXT]) state_d = ARB_LOCK1;
        end
    end
`else
    assign lock_only = 2'b00;
`endif

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (lock_only != 2'b00)     gnt = lock_only & bus.req_i;
            else if (bus.req_i == 2'b11) gnt = (wait_cnt_q == 8'(MAX_WAIT)) ? 2'b10 : 2'b01;
            else                         gnt = bus.req_i;
        end
    end

    always_comb begin
        wait_cnt_d = 8'd0;
        if (bus.req_i[PORT_EXT] && !gnt[PORT_EXT])
            wait_cnt_d = (wait_cnt_q == 8'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) wait_cnt_q <= 8'd0;
        else       wait_cnt_q <= wait_cnt_d;
    end

    assign win             = gnt[PORT_EXT];
    assign bus.gnt_o       = gnt;
    assign bus.cpu_stall_o = bus.req_i[PORT_CPU] & ~gnt[PORT_CPU] & ~reset;
    assign bus.mem_read    = (|gnt) & ~bus.we_i[win];
    assign bus.mem_write   = (|gnt) & bus.we_i[win];
    assign bus.mem_address = !(|gnt) ? '0 :
                             win ? bus.addr_i[PORT_EXT*ADDR_W +: ADDR_W]
                                 : bus.addr_i[PORT_CPU*ADDR_W +: ADDR_W];
    assign bus.mem_data_in = !(|gnt) ? '0 :
                             win ? bus.wdata_i[PORT_EXT*DATA_W +: DATA_W]
                                 : bus.wdata_i[PORT_CPU*DATA_W +: DATA_W];

    assign push = '{valid: bus.mem_read, port: win};

    arb_rd_tag_pipe #(.MEM_RD_LAT(MEM_RD_LAT)) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .tag_o  (tag)
    );

    // Gate with reset so nothing surfaces during the cycle the pipe is being cleared.
    assign rv           = (tag.valid && !reset) ? (tag.port ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rvalid_o = rv;
    assign bus.rdata_o  = (|rv) ? bus.mem_data_out : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, lock sequence (ARB_LOCK_EN)
// and randomized traffic against a transaction-level reference model.
module tb_data_mem_arbiter;
    import arb_pkg::*;
    localparam int AW = 32, DW = 32, LAT = 3, MW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(LAT), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory environment: fixed read latency, writes land at the edge.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] mpipe [LAT];

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return {a[15:0] ^ 16'hA5A5, 16'h1234 + a[15:0]};
    endfunction

    function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        for (int i = LAT-1; i > 0; i--) mpipe[i] <= mpipe[i-1];
        mpipe[0] <= bus.mem_read ? mem_rd(bus.mem_address) : 32'h0BAD_0BAD;
        if (bus.mem_write) mem[bus.mem_address] = bus.mem_data_in;
    end
    assign bus.mem_data_out = mpipe[LAT-1];

    // Reference model state: expected returns as a queue of due-cycle records.
    typedef struct { int due; int port; logic [DW-1:0] data; } ret_t;
    ret_t rq[$];
    logic [DW-1:0] shadow [logic [AW-1:0]];
    int wcnt, owner, cyc;
    int n_tests, n_fail;
    int m_g, m_eo;
    logic m_er, m_ew;
    logic [AW-1:0] m_ea;
    logic [DW-1:0] m_ed;

    function automatic logic [DW-1:0] shadow_rd(logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(logic r, logic [1:0] req, logic [1:0] we, logic [1:0] lock,
                         logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] w0, logic [DW-1:0] w1);
        reset       = r;
        bus.req_i   = req;
        bus.we_i    = we;
        bus.lock_i  = lock;
        bus.addr_i  = {a1, a0};
        bus.wdata_i = {w1, w0};
    endtask

    task automatic check();
        logic [1:0] eg, erv;
        logic [DW-1:0] erd;
        #1;
        m_eo = -1;
`ifdef ARB_LOCK_EN
        if (owner >= 0 && bus.lock_i[owner]) m_eo = owner;
`endif
        if (reset)                    m_g = -1;
        else if (m_eo >= 0)           m_g = bus.req_i[m_eo] ? m_eo : -1;
        else if (bus.req_i == 2'b11)  m_g = (wcnt == MW) ? 1 : 0;
        else if (bus.req_i[0])        m_g = 0;
        else if (bus.req_i[1])        m_g = 1;
        else                          m_g = -1;
        eg   = (m_g < 0) ? 2'b00 : (m_g == 1 ? 2'b10 : 2'b01);
        m_er = (m_g >= 0) && !bus.we_i[m_g];
        m_ew = (m_g >= 0) && bus.we_i[m_g];
        m_ea = (m_g < 0) ? '0 : bus.addr_i[m_g*AW +: AW];
        m_ed = (m_g < 0) ? '0 : bus.wdata_i[m_g*DW +: DW];
        erv = 2'b00;
        erd = '0;
        if (!reset && rq.size() > 0 && rq[0].due == cyc) begin
            erv = (rq[0].port == 1) ? 2'b10 : 2'b01;
            erd = rq[0].data;
            void'(rq.pop_front());
        end
        chk("gnt",       bus.gnt_o, eg);
        chk("cpu_stall", bus.cpu_stall_o, !reset && bus.req_i[0] && !eg[0]);
        chk("mem_read",  bus.mem_read, m_er);
        chk("mem_write", bus.mem_write, m_ew);
        chk("mem_addr",  bus.mem_address, m_ea);
        chk("mem_wdata", bus.mem_data_in, m_ed);
        chk("rvalid",    bus.rvalid_o, erv);
        chk("rdata",     bus.rdata_o, erd);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            wcnt  = 0;
            owner = -1;
            rq.delete();
        end else begin
            if (bus.req_i[1] && m_g != 1) wcnt = (wcnt < MW) ? wcnt + 1 : MW;
            else                          wcnt = 0;
            if (m_er) rq.push_back('{cyc + LAT, m_g, shadow_rd(m_ea)});
            if (m_ew) shadow[m_ea] = m_ed;
`ifdef ARB_LOCK_EN
            owner = m_eo;
            if (m_eo < 0 && m_g >= 0 && bus.lock_i[m_g]) owner = m_g;
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic rst; logic [1:0] req, we; logic [AW-1:0] a0, a1; logic [DW-1:0] w0, w1;
        logic [1:0] eg; logic es;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t v(logic rst, logic [1:0] req, logic [1:0] we, logic [AW-1:0] a0,
                               logic [AW-1:0] a1, logic [DW-1:0] w0, logic [DW-1:0] w1,
                               logic [1:0] eg, logic es);
        vec_t r;
        r = '{rst, req, we, a0, a1, w0, w1, eg, es};
        return r;
    endfunction

    function automatic vec_t idle();
        return v(1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    endfunction

    initial begin
        logic [1:0] rqr, wer, lkr;
        logic r;
        n_tests = 0; n_fail = 0; wcnt = 0; owner = -1; cyc = 0;
        mem[32'h10]    = 32'hDEADBEEF;
        shadow[32'h10] = 32'hDEADBEEF;

        // reset with both ports requesting
        vt.push_back(v(1, 2'b11, 2'b00, 1, 2, 0, 0, 2'b00, 0));
        vt.push_back(v(1, 2'b11, 2'b00, 1, 2, 0, 0, 2'b00, 0));
        vt.push_back(idle());
        // single CPU read of 0x10
        vt.push_back(v(0, 2'b01, 2'b00, 32'h10, 0, 0, 0, 2'b01, 0));
        repeat (3) vt.push_back(idle());
        // contention: port 1 wins after MW denials
        repeat (3) vt.push_back(v(0, 2'b11, 2'b00, 1, 2, 0, 0, 2'b01, 0));
        vt.push_back(v(0, 2'b11, 2'b00, 1, 2, 0, 0, 2'b10, 1));
        repeat (2) vt.push_back(v(0, 2'b11, 2'b00, 3, 4, 0, 0, 2'b01, 0));
        // port 1 drops at wait_cnt=2: counter restarts
        vt.push_back(v(0, 2'b01, 2'b00, 5, 6, 0, 0, 2'b01, 0));
        repeat (3) vt.push_back(v(0, 2'b11, 2'b00, 7, 8, 0, 0, 2'b01, 0));
        vt.push_back(v(0, 2'b11, 2'b00, 7, 8, 0, 0, 2'b10, 1));
        repeat (3) vt.push_back(idle());
        // port 1 writes 0x55 to 0x20, port 0 reads it back
        vt.push_back(v(0, 2'b10, 2'b10, 0, 32'h20, 0, 32'h55, 2'b10, 0));
        vt.push_back(v(0, 2'b01, 2'b00, 32'h20, 0, 0, 0, 2'b01, 0));
        repeat (3) vt.push_back(idle());
        // reset one cycle after a read grant kills the return
        vt.push_back(v(0, 2'b01, 2'b00, 32'h30, 0, 0, 0, 2'b01, 0));
        vt.push_back(v(1, 2'b01, 2'b00, 32'h30, 0, 0, 0, 2'b00, 0));
        repeat (5) vt.push_back(idle());
        // port 1 read return coincides with a port 0 write
        vt.push_back(v(0, 2'b10, 2'b00, 0, 5, 0, 0, 2'b10, 0));
        repeat (2) vt.push_back(idle());
        vt.push_back(v(0, 2'b01, 2'b01, 7, 0, 32'h77, 0, 2'b01, 0));
        repeat (2) vt.push_back(idle());

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].req, vt[i].we, 2'b00, vt[i].a0, vt[i].a1, vt[i].w0, vt[i].w1);
            check();
            chk("tbl_gnt", bus.gnt_o, vt[i].eg);
            chk("tbl_stall", bus.cpu_stall_o, vt[i].es);
            advance();
        end

`ifdef ARB_LOCK_EN
        drive(0, 2'b10, 2'b00, 2'b10, 0, 9, 0, 0);
        check(); chk("lock_take", bus.gnt_o, 2'b10); advance();
        repeat (5) begin
            drive(0, 2'b11, 2'b00, 2'b10, 1, 9, 0, 0);
            check(); chk("lock_hold_gnt", bus.gnt_o, 2'b10); chk("lock_hold_stall", bus.cpu_stall_o, 1'b1);
            advance();
        end
        drive(0, 2'b11, 2'b00, 2'b00, 1, 9, 0, 0);
        check(); chk("lock_release", bus.gnt_o, 2'b01); advance();
`endif

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            rqr = 2'($urandom_range(0, 3));
            wer = 2'($urandom_range(0, 3));
            lkr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            drive(r, rqr, wer, lkr, 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                  $urandom, $urandom);
            check();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU execute/memory stage, port 1 is a DMA/debug loader.
- Fixed-priority arbitration in favour of the CPU, with a starvation override for port 1.
- Tracks in-flight reads and returns read data with per-port valid.
- Produces the CPU stall term consumed by the pipeline hazard logic.

Parameters:
- ADDR_W, 32, address width per port.
- DATA_W, 32, data width.
- MEM_RD_LAT, 1, cycles from issuing a read to valid mem_data_out. Legal range 1..4.
- MAX_WAIT, 8, consecutive denied cycles of port 1 before it is forced to win. Legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  2  access request per port; must stay high with stable we/addr/wdata until the matching gnt_o.
- we_i  in  2  1 = write, 0 = read, per port.
- addr_i  in  2*ADDR_W  port p address at [p*ADDR_W +: ADDR_W].
- wdata_i  in  2*DATA_W  port p write data at [p*DATA_W +: DATA_W].
- lock_i  in  2  ownership lock request; used only with ARB_LOCK_EN.
- gnt_o  out  2  one-hot or zero; access accepted this cycle (combinational).
- cpu_stall_o  out  1  equals req_i[0] & ~gnt_o[0].
- rvalid_o  out  2  read data valid for port p.
- rdata_o  out  DATA_W  read data, shared; qualified by rvalid_o.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  memory write data.
- mem_data_out  in  DATA_W  memory read data, valid MEM_RD_LAT cycles after mem_read.

Behaviour:
- At most one memory command per cycle.
  - mem_read = |gnt_o & ~we of the winner.
  - mem_write = |gnt_o & we of the winner.
  - mem_address and mem_data_in are muxed from the winner.
  - When no port is granted, all memory outputs are 0.
- Arbitration, combinational in the same cycle:
  - Only one port requests: that port wins.
  - Both request: port 0 wins, unless wait_cnt == MAX_WAIT, in which case port 1 wins.
- wait_cnt (8-bit register):
  - Increments when req_i[1] & ~gnt_o[1].
  - Saturates at MAX_WAIT.
  - Clears to 0 on gnt_o[1] or when req_i[1] is low.
- Writes: complete at grant; no response.
- Read return:
  - A tag shift register of depth MEM_RD_LAT holds {valid, port} per stage; a read grant pushes {1, winner}.
  - rvalid_o[port] = 1 exactly MEM_RD_LAT cycles after the grant.
  - rdata_o = mem_data_out that cycle; rdata_o is 0 when no rvalid_o is set.
  - Back-to-back reads from either port are allowed every cycle; returns stay in grant order.
- Simultaneous write from one port and read return to the other: both proceed; the return path is independent of the command path.
- Reset:
  - gnt_o, rvalid_o, cpu_stall_o, mem_read, mem_write are 0.
  - mem_address, mem_data_in, rdata_o are 0.
  - wait_cnt = 0, tag pipeline cleared, lock FSM = ARB_FREE.
  - Reads in flight when reset asserts never produce rvalid_o.
  - While reset is high, gnt_o = 0 regardless of req_i.
- req_i dropped before grant: legal; the request is simply abandoned. The counter rules above still apply.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: ownership FSM with states ARB_FREE, ARB_LOCK0, ARB_LOCK1.
  - ARB_FREE: normal arbitration. Goes to ARB_LOCKp when port p is granted with lock_i[p] = 1.
  - ARB_LOCKp: only port p can be granted; the starvation override is suppressed, but wait_cnt still counts. Returns to ARB_FREE on the first cycle lock_i[p] = 0; that same cycle uses normal arbitration.
- Undefined: lock_i is ignored, the FSM is absent, and arbitration is always as in Behaviour. Port list is unchanged.

Decomposition:
- Package arb_pkg holds:
  - PORT_CPU = 0, PORT_EXT = 1.
  - Lock state typedef: ARB_FREE, ARB_LOCK0, ARB_LOCK1.
  - Tag typedef {valid, port}.
  - MAX_RD_LAT = 4.
- One sub-module: arb_rd_tag_pipe, the MEM_RD_LAT-deep tag shift register producing rvalid_o. It takes clk and reset and clears on reset.

Test Plan:
- Single CPU read: req_i=01, we=0, addr 0x10, MEM_RD_LAT=1, memory returns 0xDEADBEEF -> gnt_o=01 same cycle, mem_read=1, mem_address=0x10; next cycle rvalid_o=01, rdata_o=0xDEADBEEF; cpu_stall_o=0 throughout.
- Contention: both ports request reads continuously with MAX_WAIT=3 -> port 0 granted cycles 0-2, port 1 granted cycle 3, wait_cnt back to 0. During cycle 3, cpu_stall_o=1 and rvalid returns keep grant order.
- Write then read, same address: port 1 writes 0x55 to 0x20 and is granted; port 0 then reads 0x20 -> mem_write pulse with data 0x55, followed by rvalid_o[0] with rdata 0x55.
- Reset mid-read: read granted at cycle t, MEM_RD_LAT=3, reset high at t+1 -> rvalid_o stays 0 through t+5 and all outputs are 0 while reset is high.
- Port 1 drops its request at wait_cnt=2 (MAX_WAIT=8) -> wait_cnt clears to 0 and there is no grant to port 1.
- ARB_LOCK_EN: port 1 granted with lock_i=10 and held 5 cycles while port 0 requests -> gnt_o[0]=0 and cpu_stall_o=1 for 5 cycles; port 0 is granted the cycle lock_i[1] falls.
